// File: rtl/up_counter_mod.sv
// up_counter_mod: modulo-MODULUS up counter with parallel load, synchronous
// clear, terminal-count flag and a registered wrap pulse (ovf).
// Control priority at each clock edge is clr > ld > cnt > hold.
// Build option: define UP_COUNTER_SAT_EN to select saturating mode. In that
// mode the counter holds at MODULUS-1 and ovf is tied low.
module up_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             ld,
    input  logic             cnt,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tcount,
    output logic             ovf
);

    // Reject parameter sets outside the supported range at elaboration time.
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "up_counter_mod: WIDTH=%0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "up_counter_mod: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end

    // Terminal value, held one bit wider so that comparisons never depend on
    // the natural 2**WIDTH rollover.
    localparam logic [WIDTH:0] TOP = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH:0]   inc_w;
    logic [WIDTH:0]   in_w;
    logic             wrap;
    logic [WIDTH-1:0] count_d;
`ifndef UP_COUNTER_SAT_EN
    logic             ovf_d;
`endif

    // Terminal-count flag, decoded directly from the count register.
    always_comb begin
        tcount = ({1'b0, count} == TOP);
    end

    // Next-state logic: widened increment and load clamp, applied in
    // clr > ld > cnt priority order.
    always_comb begin
        inc_w   = {1'b0, count} + (WIDTH + 1)'(1);
        in_w    = {1'b0, in};
        wrap    = (inc_w > TOP);
        count_d = count;
`ifndef UP_COUNTER_SAT_EN
        ovf_d   = 1'b0;
`endif
        if (clr) begin
            count_d = '0;
        end else if (ld) begin
            count_d = (in_w > TOP) ? TOP[WIDTH-1:0] : in;
        end else if (cnt) begin
            if (!wrap) begin
                count_d = inc_w[WIDTH-1:0];
            end else begin
`ifdef UP_COUNTER_SAT_EN
                count_d = count;
`else
                count_d = '0;
                ovf_d   = 1'b1;
`endif
            end
        end
    end

    // Count register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

`ifdef UP_COUNTER_SAT_EN
    // The counter never wraps in saturating mode, so ovf is constant low.
    always_comb begin
        ovf = 1'b0;
    end
`else
    // Wrap pulse register: high for exactly the cycle after a wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_d;
        end
    end
`endif

endmodule
